vector_output_drainer: RTL and testbench
========================================

VECTOR_OUTPUT_DRAINER -- requirements
Module: vector_output_drainer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: lane width in bits.
REQ-002 SHALL have parameter VECTOR_SIZE, default 6: lanes per vector.
REQ-003 SHALL have parameter DEPTH, default 4: vector FIFO entries, power of two, at least 2.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port outFlag, input, 1 bit: CPU output-valid strobe, one vector per high cycle.
REQ-007 SHALL have port out, input, DATA_WIDTH*VECTOR_SIZE bits: CPU output vector; lane k is out[k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port wordData, output, DATA_WIDTH bits: current lane presented to the consumer.
REQ-009 SHALL have port wordValid, output, 1 bit: wordData is valid.
REQ-010 SHALL have port wordReady, input, 1 bit: consumer accepts wordData.
REQ-011 SHALL have port lastLane, output, 1 bit: the current word is lane VECTOR_SIZE-1.
REQ-012 SHALL have port full, output, 1 bit: FIFO holds DEPTH vectors.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, a vector was dropped.

Function
REQ-014 SHALL capture out into the FIFO on a rising edge with outFlag=1 and count<DEPTH, where count is the pre-edge value.
REQ-015 SHALL drop the vector and set overflow when outFlag=1 and count==DEPTH; this applies even if a vector completes in the same cycle.
REQ-016 SHALL use a two-state FSM: IDLE (wordValid=0) and SEND (wordValid=1).
REQ-017 SHALL go IDLE->SEND on the edge after which count>0.
REQ-018 SHALL make the first word of a vector written at edge N visible from edge N+1 when the FIFO was empty: one cycle latency.
REQ-019 SHALL count a word transfer when wordValid=1 and wordReady=1 at the rising edge.
REQ-020 SHALL hold wordData and lastLane stable while wordValid=1 and wordReady=0.
REQ-021 SHALL send lanes in order 0 to VECTOR_SIZE-1 and advance the lane index by one per transfer.
REQ-022 SHALL, on the transfer with lastLane=1, pop the head entry, reset the lane index to 0, and go to SEND if count after the edge is >0, else to IDLE.
REQ-023 SHALL, on a simultaneous push and pop, apply both so that count is unchanged.
REQ-024 SHALL wrap the read and write pointers modulo DEPTH.
REQ-025 SHALL make a back-to-back vector's lane 0 follow the previous vector's lane VECTOR_SIZE-1 with no bubble.
REQ-026 SHALL set full = (count==DEPTH) as a registered-state decode.
REQ-027 SHALL clear overflow only by reset.

Reset
REQ-028 SHALL, when reset=1 at a rising edge, set state=IDLE, count=0, pointers=0, lane index=0, and overflow=0.
REQ-029 SHALL drive wordValid=0, lastLane=0, full=0, and wordData=0 after reset.
REQ-030 SHALL, on reset mid-vector, discard all buffered and partially sent vectors; the consumer sees no further words of them.
REQ-031 SHALL ignore outFlag in any cycle where reset=1.

Configuration
REQ-032 SHALL, with macro VECTOR_DRAIN_PARITY_EN defined, add output port wordParity, 1 bit, equal to the XOR reduction of wordData and valid alongside wordValid; it is 0 after reset.
REQ-033 SHALL, without VECTOR_DRAIN_PARITY_EN, have no wordParity port, with all other behaviour identical.

Verification
REQ-034 SHALL cover a single vector: one outFlag pulse with lanes 0x0001..0x0006 and wordReady=1 -> wordValid from the next cycle, words 1..6 on 6 consecutive cycles, lastLane=1 only on 0x0006, then IDLE.
REQ-035 SHALL cover backpressure: wordReady=0 for 3 cycles during lane 2 -> wordData holds lane 2 and no lane is skipped or duplicated.
REQ-036 SHALL cover overflow: 5 outFlag pulses with wordReady=0 and DEPTH=4 -> full=1 after the 4th, overflow=1 after the 5th, and exactly 4 vectors drain in order.
REQ-037 SHALL cover simultaneous events: outFlag=1 while full and on the final-lane transfer -> the new vector is dropped, overflow=1, and count becomes 3.
REQ-038 SHALL cover reset mid-vector: reset at lane 3 -> wordValid=0 the next cycle and, with no new outFlag, no words afterwards.
REQ-039 SHALL cover parity: with VECTOR_DRAIN_PARITY_EN, lane 0x0007 -> wordParity=1, and lane 0x0003 -> wordParity=0.

Source files
------------

// File: rtl/vector_output_drainer.sv
// vector_output_drainer: buffers whole CPU output vectors in a small FIFO and
// serialises them lane by lane onto a valid/ready word stream.
// Optional feature: define VECTOR_DRAIN_PARITY_EN to add the wordParity output.
module vector_output_drainer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned VECTOR_SIZE = 6,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                outFlag,
  input  logic [DATA_WIDTH*VECTOR_SIZE-1:0]   out,
  output logic [DATA_WIDTH-1:0]               wordData,
  output logic                                wordValid,
  input  logic                                wordReady,
  output logic                                lastLane,
  output logic                                full,
  output logic                                overflow
`ifdef VECTOR_DRAIN_PARITY_EN
  ,
  output logic                                wordParity
`endif
);

  localparam int unsigned VEC_W  = DATA_WIDTH * VECTOR_SIZE;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LANE_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(VECTOR_SIZE - 1);
  localparam logic              ONE_LANE  = (VECTOR_SIZE == 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t              r_state;
  logic [VEC_W-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [LANE_W-1:0]   r_lane;

  logic                w_push;
  logic                w_drop;
  logic                w_xfer;
  logic                w_pop;
  logic                w_bypass;
  logic [CNT_W-1:0]    w_count_nxt;
  logic [PTR_W-1:0]    w_rd_ptr_inc;
  logic [LANE_W-1:0]   w_lane_inc;
  logic [VEC_W-1:0]    w_head_vec;
  logic [VEC_W-1:0]    w_next_vec;
  logic [DATA_WIDTH-1:0] w_lane0_head;
  logic [DATA_WIDTH-1:0] w_lane_adv;
  logic [DATA_WIDTH-1:0] w_lane0_next;

  // Push/pop qualification; the occupancy test uses the pre-edge count, so a
  // vector arriving while full is dropped even if a pop happens this cycle.
  assign w_push       = outFlag & ~reset & (r_count != CNT_FULL);
  assign w_drop       = outFlag & ~reset & (r_count == CNT_FULL);
  assign w_xfer       = wordValid & wordReady;
  assign w_pop        = w_xfer & lastLane;
  assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);
  assign w_lane_inc   = r_lane + LANE_W'(1);

  // Lane selection; when the only buffered vector retires while a new one is
  // being written, the new vector is still on the input bus, so bypass it.
  assign w_bypass     = (r_count == CNT_W'(1)) & w_push;
  assign w_head_vec   = r_mem[r_rd_ptr];
  assign w_next_vec   = w_bypass ? out : r_mem[w_rd_ptr_inc];
  assign w_lane0_head = w_head_vec[DATA_WIDTH-1:0];
  assign w_lane_adv   = w_head_vec[32'(w_lane_inc) * DATA_WIDTH +: DATA_WIDTH];
  assign w_lane0_next = w_next_vec[DATA_WIDTH-1:0];

  // Vector storage write port.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= out;
    end
  end

  // FIFO bookkeeping and the IDLE/SEND serialiser with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_lane     <= '0;
      wordData   <= '0;
      wordValid  <= 1'b0;
      lastLane   <= 1'b0;
      full       <= 1'b0;
      overflow   <= 1'b0;
`ifdef VECTOR_DRAIN_PARITY_EN
      wordParity <= 1'b0;
`endif
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_drop) begin
        overflow <= 1'b1;
      end
      r_count <= w_count_nxt;
      full    <= (w_count_nxt == CNT_FULL);

      case (r_state)
        ST_IDLE: begin
          if (r_count != '0) begin
            r_state    <= ST_SEND;
            r_lane     <= '0;
            wordValid  <= 1'b1;
            wordData   <= w_lane0_head;
            lastLane   <= ONE_LANE;
`ifdef VECTOR_DRAIN_PARITY_EN
            wordParity <= ^w_lane0_head;
`endif
          end
        end
        ST_SEND: begin
          if (w_xfer) begin
            if (lastLane) begin
              r_rd_ptr <= w_rd_ptr_inc;
              r_lane   <= '0;
              if (w_count_nxt != '0) begin
                wordData   <= w_lane0_next;
                lastLane   <= ONE_LANE;
`ifdef VECTOR_DRAIN_PARITY_EN
                wordParity <= ^w_lane0_next;
`endif
              end else begin
                r_state    <= ST_IDLE;
                wordValid  <= 1'b0;
                wordData   <= '0;
                lastLane   <= 1'b0;
`ifdef VECTOR_DRAIN_PARITY_EN
                wordParity <= 1'b0;
`endif
              end
            end else begin
              r_lane     <= w_lane_inc;
              wordData   <= w_lane_adv;
              lastLane   <= (w_lane_inc == LANE_LAST);
`ifdef VECTOR_DRAIN_PARITY_EN
              wordParity <= ^w_lane_adv;
`endif
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          wordValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_output_drainer.sv
// Scoreboard bench for vector_output_drainer (default parameters).
module tb_vector_output_drainer;

  localparam int unsigned DW = 16;
  localparam int unsigned VS = 6;
  localparam int unsigned DP = 4;
  localparam int unsigned VW = DW * VS;

  logic          clock     = 1'b0;
  logic          reset     = 1'b1;
  logic          outFlag   = 1'b0;
  logic          wordReady = 1'b0;
  logic [VW-1:0] out       = '0;
  logic [DW-1:0] wordData;
  logic          wordValid;
  logic          lastLane;
  logic          full;
  logic          overflow;
`ifdef VECTOR_DRAIN_PARITY_EN
  logic          wordParity;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [DW:0] sb [$];
  logic [DW:0] mon_exp;

  vector_output_drainer #(
    .DATA_WIDTH (DW),
    .VECTOR_SIZE(VS),
    .DEPTH      (DP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .outFlag   (outFlag),
    .out       (out),
    .wordData  (wordData),
    .wordValid (wordValid),
    .wordReady (wordReady),
    .lastLane  (lastLane),
    .full      (full),
    .overflow  (overflow)
`ifdef VECTOR_DRAIN_PARITY_EN
    ,
    .wordParity(wordParity)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Every word transfer is checked against the scoreboard, in order.
  always @(negedge clock) begin
    if (!reset && wordValid && wordReady) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_word: got data=%h last=%b, expected no word", wordData, lastLane);
      end else begin
        mon_exp = sb.pop_front();
        if ({wordData, lastLane} !== mon_exp) begin
          n_err++;
          $display("FAIL sb_word: got data=%h last=%b, expected data=%h last=%b",
                   wordData, lastLane, mon_exp[DW:1], mon_exp[0]);
        end
      end
`ifdef VECTOR_DRAIN_PARITY_EN
      n_vec++;
      if (wordParity !== ^wordData) begin
        n_err++;
        $display("FAIL sb_parity: got %b expected %b", wordParity, ^wordData);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [VW-1:0] build_vec(input logic [DW-1:0] base);
    logic [VW-1:0] v;
    for (int k = 0; k < VS; k++) begin
      v[k*DW +: DW] = base + DW'(k);
    end
    return v;
  endfunction

  task automatic expect_vec(input logic [VW-1:0] v);
    for (int k = 0; k < VS; k++) begin
      sb.push_back({v[k*DW +: DW], (k == VS - 1)});
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !wordValid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    outFlag = 1'b0;
    tick();
    reset   = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    outFlag = 1'b1;
    out     = build_vec(16'h00A0);
    tick();
    tick();
    outFlag = 1'b0;
    reset   = 1'b0;
    n_vec++;
    if (wordValid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", wordValid); end
    n_vec++;
    if (lastLane !== 1'b0) begin n_err++; $display("FAIL rst_last: got %b expected 0", lastLane); end
    n_vec++;
    if (full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b expected 0", full); end
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    n_vec++;
    if (wordData !== 16'h0000) begin n_err++; $display("FAIL rst_data: got %h expected 0000", wordData); end
`ifdef VECTOR_DRAIN_PARITY_EN
    n_vec++;
    if (wordParity !== 1'b0) begin n_err++; $display("FAIL rst_parity: got %b expected 0", wordParity); end
`endif
    repeat (3) tick();
    n_vec++;
    if (wordValid !== 1'b0) begin n_err++; $display("FAIL rst_flag_ignored: got valid=%b expected 0", wordValid); end
  endtask

  task automatic test_single();
    logic [VW-1:0] v;
    bit ok;
    do_reset();
    wordReady = 1'b1;
    v = build_vec(16'h0001);
    outFlag = 1'b1;
    out     = v;
    expect_vec(v);
    tick();
    outFlag = 1'b0;
    n_vec++;
    if (wordValid !== 1'b0) begin n_err++; $display("FAIL single_latency: got valid=%b expected 0", wordValid); end
    tick();
    for (int i = 0; i < VS; i++) begin
      n_vec++;
      if (wordValid !== 1'b1 || wordData !== DW'(i + 1) || lastLane !== (i == VS - 1)) begin
        n_err++;
        $display("FAIL single_word%0d: got valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                 i, wordValid, wordData, lastLane, DW'(i + 1), (i == VS - 1));
      end
      tick();
    end
    n_vec++;
    if (wordValid !== 1'b0) begin n_err++; $display("FAIL single_idle: got valid=%b expected 0", wordValid); end
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL single_drain: got %0d words pending expected 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] v;
    bit ok;
    do_reset();
    wordReady = 1'b1;
    v = build_vec(16'h0010);
    outFlag = 1'b1;
    out     = v;
    expect_vec(v);
    tick();
    outFlag = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (wordData !== 16'h0012) begin n_err++; $display("FAIL bp_reach_lane2: got %h expected 0012", wordData); end
    wordReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (wordValid !== 1'b1 || wordData !== 16'h0012 || lastLane !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h last=%b expected valid=1 data=0012 last=0",
                 i, wordValid, wordData, lastLane);
      end
    end
    wordReady = 1'b1;
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL bp_drain: got %0d words pending expected 0", sb.size()); end
  endtask

  task automatic test_overflow();
    logic [VW-1:0] v;
    bit ok;
    do_reset();
    wordReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      v = build_vec(DW'(16'h0100 * (k + 1)));
      outFlag = 1'b1;
      out     = v;
      if (k < 4) expect_vec(v);
      tick();
      if (k == 2) begin
        n_vec++;
        if (full !== 1'b0) begin n_err++; $display("FAIL ovf_not_full: got %b expected 0", full); end
      end
      if (k == 3) begin
        n_vec++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          n_err++;
          $display("FAIL ovf_full4: got full=%b ovf=%b expected full=1 ovf=0", full, overflow);
        end
      end
      if (k == 4) begin
        n_vec++;
        if (full !== 1'b1 || overflow !== 1'b1) begin
          n_err++;
          $display("FAIL ovf_drop5: got full=%b ovf=%b expected full=1 ovf=1", full, overflow);
        end
      end
    end
    outFlag   = 1'b0;
    wordReady = 1'b1;
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL ovf_drain: got %0d words pending expected 0", sb.size()); end
    n_vec++;
    if (overflow !== 1'b1 || full !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_sticky: got ovf=%b full=%b expected ovf=1 full=0", overflow, full);
    end
    do_reset();
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_reset_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_simultaneous();
    logic [VW-1:0] v;
    bit ok;
    do_reset();
    wordReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v = build_vec(DW'(16'h0200 + 16'h0100 * k));
      outFlag = 1'b1;
      out     = v;
      expect_vec(v);
      tick();
    end
    outFlag = 1'b0;
    n_vec++;
    if (full !== 1'b1) begin n_err++; $display("FAIL sim_full: got %b expected 1", full); end
    wordReady = 1'b1;
    repeat (5) tick();
    n_vec++;
    if (lastLane !== 1'b1 || wordData !== 16'h0205) begin
      n_err++;
      $display("FAIL sim_at_last: got last=%b data=%h expected last=1 data=0205", lastLane, wordData);
    end
    outFlag = 1'b1;
    out     = build_vec(16'h0600);
    tick();
    outFlag   = 1'b0;
    wordReady = 1'b0;
    n_vec++;
    if (overflow !== 1'b1 || full !== 1'b0 || wordValid !== 1'b1 || wordData !== 16'h0300) begin
      n_err++;
      $display("FAIL sim_drop: got ovf=%b full=%b valid=%b data=%h expected ovf=1 full=0 valid=1 data=0300",
               overflow, full, wordValid, wordData);
    end
    v = build_vec(16'h0700);
    outFlag = 1'b1;
    out     = v;
    expect_vec(v);
    tick();
    outFlag = 1'b0;
    n_vec++;
    if (full !== 1'b1) begin n_err++; $display("FAIL sim_count3: got full=%b expected 1", full); end
    wordReady = 1'b1;
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL sim_drain: got %0d words pending expected 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] va, vb, vc;
    bit ok;
    do_reset();
    wordReady = 1'b1;
    va = build_vec(16'h0A00);
    vb = build_vec(16'h0B00);
    vc = build_vec(16'h0C00);
    outFlag = 1'b1;
    out     = va;
    expect_vec(va);
    tick();
    out = vb;
    expect_vec(vb);
    tick();
    outFlag = 1'b0;
    n_vec++;
    if (wordValid !== 1'b1 || wordData !== 16'h0A00) begin
      n_err++;
      $display("FAIL b2b_start: got valid=%b data=%h expected valid=1 data=0A00", wordValid, wordData);
    end
    for (int j = 0; j < 2 * VS; j++) begin
      n_vec++;
      if (wordValid !== 1'b1 || lastLane !== ((j % VS) == VS - 1)) begin
        n_err++;
        $display("FAIL b2b_stream%0d: got valid=%b last=%b expected valid=1 last=%b",
                 j, wordValid, lastLane, ((j % VS) == VS - 1));
      end
      if (j == 2 * VS - 1) begin
        outFlag = 1'b1;
        out     = vc;
        expect_vec(vc);
      end
      tick();
      outFlag = 1'b0;
    end
    n_vec++;
    if (wordValid !== 1'b1 || wordData !== 16'h0C00) begin
      n_err++;
      $display("FAIL b2b_bypass: got valid=%b data=%h expected valid=1 data=0C00", wordValid, wordData);
    end
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL b2b_drain: got %0d words pending expected 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] v;
    bit found;
    int seen;
    do_reset();
    wordReady = 1'b1;
    v = build_vec(16'h0D00);
    outFlag = 1'b1;
    out     = v;
    expect_vec(v);
    tick();
    v = build_vec(16'h0E00);
    out = v;
    expect_vec(v);
    tick();
    outFlag = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wordValid && wordData == 16'h0D03) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL rmid_lane3: got data=%h expected 0D03", wordData); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    n_vec++;
    if (wordValid !== 1'b0 || lastLane !== 1'b0 || wordData !== 16'h0000) begin
      n_err++;
      $display("FAIL rmid_cleared: got valid=%b last=%b data=%h expected 0 0 0000", wordValid, lastLane, wordData);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wordValid) seen++;
    end
    n_vec++;
    if (seen != 0) begin n_err++; $display("FAIL rmid_silent: got %0d valid cycles expected 0", seen); end
  endtask

`ifdef VECTOR_DRAIN_PARITY_EN
  task automatic test_parity();
    logic [VW-1:0] v;
    bit ok;
    do_reset();
    wordReady = 1'b0;
    v = build_vec(16'h0001);
    v[0*DW +: DW] = 16'h0007;
    v[1*DW +: DW] = 16'h0003;
    v[4*DW +: DW] = 16'h8000;
    v[5*DW +: DW] = 16'hFFFF;
    outFlag = 1'b1;
    out     = v;
    expect_vec(v);
    tick();
    outFlag = 1'b0;
    tick();
    n_vec++;
    if (wordValid !== 1'b1 || wordData !== 16'h0007 || wordParity !== 1'b1) begin
      n_err++;
      $display("FAIL par_0007: got valid=%b data=%h par=%b expected 1 0007 1", wordValid, wordData, wordParity);
    end
    wordReady = 1'b1;
    tick();
    wordReady = 1'b0;
    n_vec++;
    if (wordData !== 16'h0003 || wordParity !== 1'b0) begin
      n_err++;
      $display("FAIL par_0003: got data=%h par=%b expected 0003 0", wordData, wordParity);
    end
    wordReady = 1'b1;
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL par_drain: got %0d words pending expected 0", sb.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
`ifdef VECTOR_DRAIN_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
